// File: rtl/sba_axi_pkg.sv
// sba_axi_pkg -- FSM state encoding and AXI response codes shared by the
// SBA-to-AXI-Lite bridge and anything that observes it.
package sba_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than OKAY is reported upstream as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/sba_axi_lite_bridge.sv
// sba_axi_lite_bridge -- turns single SBA requests into AXI-Lite transactions,
// one outstanding at a time, and reports completion with a one-cycle
// r_valid_o pulse. Define SBA_AXI_ERRCNT_EN to add a saturating 16-bit count
// of error responses on err_cnt_o; without it err_cnt_o is tied to zero.
module sba_axi_lite_bridge
  import sba_axi_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64  // 32 or 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // SBA responder
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic                   gnt_o,
  output logic                   r_valid_o,
  output logic [DataWidth-1:0]   r_rdata_o,
  // AXI-Lite write master
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [1:0]             b_resp_i,
  // AXI-Lite read master
  output logic                   ar_valid_o,
  input  logic                   ar_ready_i,
  output logic [AddrWidth-1:0]   ar_addr_o,
  input  logic                   r_valid_i,
  output logic                   r_ready_o,
  input  logic [DataWidth-1:0]   r_data_i,
  input  logic [1:0]             r_resp_i,
  // Status
  output logic                   err_o,
  output logic [15:0]            err_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  state_e                 state_q, state_d;
  logic                   grant;
  logic                   aw_done_q, w_done_q;
  logic                   err_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   be_q;
  logic [DataWidth-1:0]   rdata_q;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    aw_valid_o = 1'b0;
    w_valid_o  = 1'b0;
    b_ready_o  = 1'b0;
    ar_valid_o = 1'b0;
    r_ready_o  = 1'b0;
    r_valid_o  = 1'b0;
    err_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant = req_i;
        if (req_i) state_d = we_i ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        // AW and W retire independently; leave once both have handshaken,
        // counting a handshake that completes on this edge.
        aw_valid_o = ~aw_done_q;
        w_valid_o  = ~w_done_q;
        if ((aw_done_q | aw_ready_i) & (w_done_q | w_ready_i)) state_d = WR_RESP;
      end
      WR_RESP: begin
        b_ready_o = 1'b1;
        if (b_valid_i) state_d = DONE;
      end
      RD_REQ: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) state_d = RD_RESP;
      end
      RD_RESP: begin
        r_ready_o = 1'b1;
        if (r_valid_i) state_d = DONE;
      end
      DONE: begin
        // A request seen here waits for the IDLE cycle that follows.
        r_valid_o = 1'b1;
        err_o     = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The grant is masked while reset is held so gnt_o reads zero then.
  assign gnt_o = grant & rst_ni;

  // Track which of the AW / W handshakes have already completed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (grant) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == WR_REQ) begin
      if (aw_ready_i) aw_done_q <= 1'b1;
      if (w_ready_i)  w_done_q  <= 1'b1;
    end
  end

  // Capture the SBA request on the grant edge.
  // NOTE: these registers carry no reset; they are only observed while the
  // AXI valid they qualify is high, which is never straight out of reset.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      be_q    <= be_i;
    end
  end

  // Register the completion data and error flag on the B or R handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if ((state_q == WR_RESP) && b_valid_i) begin
      rdata_q <= '0;
      err_q   <= resp_is_err(b_resp_i);
    end else if ((state_q == RD_RESP) && r_valid_i) begin
      rdata_q <= r_data_i;
      err_q   <= resp_is_err(r_resp_i);
    end
  end

  assign aw_addr_o = addr_q;
  assign ar_addr_o = addr_q;
  assign w_data_o  = wdata_q;
  assign w_strb_o  = be_q;
  assign r_rdata_o = rdata_q;

`ifdef SBA_AXI_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of error completions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            err_cnt_q <= '0;
    else if (err_o && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sba_axi_lite_bridge.sv
// tb_sba_axi_lite_bridge -- directed bench for sba_axi_lite_bridge with a
// transaction-level model of the bridge and a configurable AXI-Lite slave.
module tb_sba_axi_lite_bridge;
  import sba_axi_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;
`ifdef SBA_AXI_ERRCNT_EN
  localparam bit ErrCntOn = 1'b1;
`else
  localparam bit ErrCntOn = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [SW-1:0] be_i;
  logic          gnt_o, r_valid_o;
  logic [DW-1:0] r_rdata_o;
  logic          aw_valid_o, aw_ready_i;
  logic [AW-1:0] aw_addr_o;
  logic          w_valid_o, w_ready_i;
  logic [DW-1:0] w_data_o;
  logic [SW-1:0] w_strb_o;
  logic          b_valid_i, b_ready_o;
  logic [1:0]    b_resp_i;
  logic          ar_valid_o, ar_ready_i;
  logic [AW-1:0] ar_addr_o;
  logic          r_valid_i, r_ready_o;
  logic [DW-1:0] r_data_i;
  logic [1:0]    r_resp_i;
  logic          err_o;
  logic [15:0]   err_cnt_o;

  sba_axi_lite_bridge #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave behaviour knobs, written only by the stimulus process.
  int            cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_b_dly, cfg_r_dly;
  logic [1:0]    cfg_b_resp, cfg_r_resp;
  logic [DW-1:0] cfg_r_data;

  // Handshakes that complete on the coming edge, published by the monitor.
  bit aw_hs, w_hs, ar_hs, b_hs, r_hs;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] be;
  } txn_t;

  txn_t          cur;
  bit            busy, aw_done, w_done, ar_done, b_done, r_done, resp_due, exp_err;
  logic [DW-1:0] exp_data;
  logic [15:0]   exp_cnt = '0;

  // Observations for the directed checks.
  int            cyc, n_gnt, n_rv, n_err, n_bhs, n_arv;
  int            gnt_cyc, rv_cyc, aw_hs_cyc, w_hs_cyc;
  logic [DW-1:0] last_rdata;

  // Compare process: one transaction in flight, each AXI channel used once,
  // completion one cycle after the response handshake.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        busy = 0; resp_due = 0; exp_cnt = '0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
      end else begin
        check("gnt_o",      64'(gnt_o),      64'(req_i && !busy));
        check("aw_valid_o", 64'(aw_valid_o), 64'(busy && cur.we && !aw_done));
        check("w_valid_o",  64'(w_valid_o),  64'(busy && cur.we && !w_done));
        check("b_ready_o",  64'(b_ready_o),  64'(busy && cur.we && aw_done && w_done && !b_done));
        check("ar_valid_o", 64'(ar_valid_o), 64'(busy && !cur.we && !ar_done));
        check("r_ready_o",  64'(r_ready_o),  64'(busy && !cur.we && ar_done && !r_done));
        if (busy && cur.we && !aw_done) check("aw_addr_o", aw_addr_o, cur.addr);
        if (busy && cur.we && !w_done) begin
          check("w_data_o", w_data_o, cur.wdata);
          check("w_strb_o", 64'(w_strb_o), 64'(cur.be));
        end
        if (busy && !cur.we && !ar_done) check("ar_addr_o", ar_addr_o, cur.addr);
        check("r_valid_o", 64'(r_valid_o), 64'(resp_due));
        check("err_o",     64'(err_o),     64'(resp_due && exp_err));
        if (resp_due) check("r_rdata_o", r_rdata_o, exp_data);
        check("err_cnt_o", 64'(err_cnt_o), 64'(exp_cnt));

        if (gnt_o)      begin n_gnt++; gnt_cyc = cyc; end
        if (r_valid_o)  begin n_rv++; rv_cyc = cyc; last_rdata = r_rdata_o; end
        if (err_o)      n_err++;
        if (ar_valid_o) n_arv++;

        aw_hs = aw_valid_o && aw_ready_i;
        w_hs  = w_valid_o && w_ready_i;
        ar_hs = ar_valid_o && ar_ready_i;
        b_hs  = b_valid_i && b_ready_o;
        r_hs  = r_valid_i && r_ready_o;
        if (aw_hs) aw_hs_cyc = cyc;
        if (w_hs)  w_hs_cyc = cyc;
        if (b_hs)  n_bhs++;

        if (!busy) begin
          if (req_i) begin
            busy = 1;
            cur = '{we_i, addr_i, wdata_i, be_i};
            aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
          end
        end else if (resp_due) begin
          busy = 0;
          resp_due = 0;
          if (ErrCntOn && exp_err && exp_cnt != 16'hFFFF) exp_cnt++;
        end else begin
          if (aw_hs) aw_done = 1;
          if (w_hs)  w_done = 1;
          if (ar_hs) ar_done = 1;
          if (b_hs) begin
            b_done = 1; resp_due = 1; exp_data = '0; exp_err = (b_resp_i != RESP_OKAY);
          end
          if (r_hs) begin
            r_done = 1; resp_due = 1; exp_data = r_data_i; exp_err = (r_resp_i != RESP_OKAY);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- slave
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit aw_got, w_got, ar_got;

  initial begin
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_valid_i = 0; b_resp_i = '0; r_valid_i = 0; r_data_i = '0; r_resp_i = '0;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
      end else begin
        #1;
        if (aw_valid_o) begin aw_ready_i = (aw_wait >= cfg_aw_dly); aw_wait++; end
        else begin aw_ready_i = 0; aw_wait = 0; end
        if (w_valid_o) begin w_ready_i = (w_wait >= cfg_w_dly); w_wait++; end
        else begin w_ready_i = 0; w_wait = 0; end
        if (ar_valid_o) begin ar_ready_i = (ar_wait >= cfg_ar_dly); ar_wait++; end
        else begin ar_ready_i = 0; ar_wait = 0; end

        if (b_hs) b_valid_i = 0;
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got = 1;
        if (aw_got && w_got && !b_valid_i) begin
          if (b_wait >= cfg_b_dly) begin
            b_valid_i = 1; b_resp_i = cfg_b_resp; aw_got = 0; w_got = 0; b_wait = 0;
          end else b_wait++;
        end

        if (r_hs) r_valid_i = 0;
        if (ar_hs) ar_got = 1;
        if (ar_got && !r_valid_i) begin
          if (r_wait >= cfg_r_dly) begin
            r_valid_i = 1; r_data_i = cfg_r_data; r_resp_i = cfg_r_resp; ar_got = 0; r_wait = 0;
          end else r_wait++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] be, input string name);
    int g0;
    int k;
    g0 = n_gnt;
    k = 0;
    @(posedge clk_i); #1;
    req_i = 1; we_i = we; addr_i = a; wdata_i = d; be_i = be;
    do begin @(posedge clk_i); #1; k++; end while (n_gnt == g0 && k < 40);
    req_i = 0;
    check({name, "_granted"}, 64'(n_gnt - g0), 64'd1);
  endtask

  task automatic wait_rv(input int target, input string name);
    int k;
    k = 0;
    while (n_rv < target && k < 80) begin @(posedge clk_i); #1; k++; end
    check({name, "_completed"}, 64'(n_rv), 64'(target));
  endtask

  task automatic set_slave(input int aw_d, input int w_d, input int b_d, input int ar_d,
                           input int r_d, input logic [1:0] b_r, input logic [1:0] r_r,
                           input logic [DW-1:0] rd);
    cfg_aw_dly = aw_d; cfg_w_dly = w_d; cfg_b_dly = b_d; cfg_ar_dly = ar_d; cfg_r_dly = r_d;
    cfg_b_resp = b_r; cfg_r_resp = r_r; cfg_r_data = rd;
  endtask

  int g0, rv0, e0, b0, a0, k;

  initial begin
    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, '0);
    rst_ni = 0;

    // Reset state, with a request pending to show the grant is masked.
    repeat (3) @(posedge clk_i);
    #1 req_i = 1;
    #1;
    check("rst_gnt_o",     64'(gnt_o), 64'd0);
    req_i = 0;
    check("rst_aw_valid",  64'(aw_valid_o), 64'd0);
    check("rst_w_valid",   64'(w_valid_o), 64'd0);
    check("rst_ar_valid",  64'(ar_valid_o), 64'd0);
    check("rst_b_ready",   64'(b_ready_o), 64'd0);
    check("rst_r_ready",   64'(r_ready_o), 64'd0);
    check("rst_r_valid",   64'(r_valid_o), 64'd0);
    check("rst_r_rdata",   r_rdata_o, 64'd0);
    check("rst_err",       64'(err_o), 64'd0);
    check("rst_err_cnt",   64'(err_cnt_o), 64'd0);
    @(posedge clk_i); #3 rst_ni = 1;

    // Plain write, B OKAY two cycles after the data is accepted.
    set_slave(0, 0, 2, 0, 0, RESP_OKAY, RESP_OKAY, '0);
    g0 = n_gnt; rv0 = n_rv; e0 = n_err;
    issue(1'b1, 64'h8000_0000, 64'hDEAD_BEEF_0000_0001, 8'hFF, "t1");
    wait_rv(rv0 + 1, "t1");
    repeat (3) @(posedge clk_i); #1;
    check("t1_gnt_cycles", 64'(n_gnt - g0), 64'd1);
    check("t1_rvalid_cycles", 64'(n_rv - rv0), 64'd1);
    check("t1_rdata", last_rdata, 64'd0);
    check("t1_err_pulses", 64'(n_err - e0), 64'd0);

    // Read with AR ready held off three cycles.
    set_slave(0, 0, 0, 3, 0, RESP_OKAY, RESP_OKAY, 64'h1234);
    rv0 = n_rv; a0 = n_arv;
    issue(1'b0, 64'h8000_0008, '0, '0, "t2");
    wait_rv(rv0 + 1, "t2");
    check("t2_ar_valid_cycles", 64'(n_arv - a0), 64'd4);
    check("t2_rdata", last_rdata, 64'h1234);

    // Write where W is accepted two cycles before AW.
    set_slave(2, 0, 1, 0, 0, RESP_OKAY, RESP_OKAY, '0);
    rv0 = n_rv; b0 = n_bhs;
    issue(1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'h0F, "t3");
    wait_rv(rv0 + 1, "t3");
    repeat (3) @(posedge clk_i); #1;
    check("t3_aw_after_w", 64'(aw_hs_cyc - w_hs_cyc), 64'd2);
    check("t3_b_accepted", 64'(n_bhs - b0), 64'd1);
    check("t3_rvalid_cycles", 64'(n_rv - rv0), 64'd1);

    // Three reads answered with SLVERR.
    set_slave(0, 0, 0, 0, 1, RESP_OKAY, RESP_SLVERR, 64'h55);
    rv0 = n_rv; e0 = n_err;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 64'h100 + 64'(i * 8), '0, '0, "t4");
      wait_rv(rv0 + i + 1, "t4");
    end
    repeat (2) @(posedge clk_i); #1;
    check("t4_err_pulses", 64'(n_err - e0), 64'd3);
    check("t4_err_cnt", 64'(err_cnt_o), ErrCntOn ? 64'd3 : 64'd0);

    // Write with AW first and a DECERR response.
    set_slave(0, 2, 0, 0, 0, RESP_DECERR, RESP_OKAY, '0);
    rv0 = n_rv; e0 = n_err;
    issue(1'b1, 64'h8000_0020, 64'hFFFF_0000_FFFF_0000, 8'hA5, "t5");
    wait_rv(rv0 + 1, "t5");
    repeat (2) @(posedge clk_i); #1;
    check("t5_err_pulses", 64'(n_err - e0), 64'd1);
    check("t5_rdata", last_rdata, 64'd0);
    check("t5_err_cnt", 64'(err_cnt_o), ErrCntOn ? 64'd4 : 64'd0);

    // Request held high through a read: the second grant lands one cycle
    // after the completion pulse.
    set_slave(0, 0, 0, 2, 3, RESP_OKAY, RESP_OKAY, 64'hA5A5);
    g0 = n_gnt; rv0 = n_rv; k = 0;
    @(posedge clk_i); #1;
    req_i = 1; we_i = 0; addr_i = 64'h200;
    do begin @(posedge clk_i); #1; k++; end while (n_gnt < g0 + 2 && k < 60);
    req_i = 0;
    check("t6_grants", 64'(n_gnt - g0), 64'd2);
    check("t6_regrant_gap", 64'(gnt_cyc - rv_cyc), 64'd1);
    wait_rv(rv0 + 2, "t6");
    check("t6_rdata", last_rdata, 64'hA5A5);

    // Reset while waiting for B: abandoned, then normal service.
    set_slave(0, 0, 30, 0, 0, RESP_OKAY, RESP_OKAY, '0);
    rv0 = n_rv; k = 0;
    issue(1'b1, 64'h300, 64'h77, 8'hFF, "t7");
    while (!b_ready_o && k < 20) begin @(posedge clk_i); #1; k++; end
    check("t7_in_wr_resp", 64'(b_ready_o), 64'd1);
    @(posedge clk_i); #3 rst_ni = 0;
    #1;
    check("t7_rst_b_ready", 64'(b_ready_o), 64'd0);
    check("t7_rst_r_valid", 64'(r_valid_o), 64'd0);
    check("t7_rst_r_rdata", r_rdata_o, 64'd0);
    check("t7_rst_err_cnt", 64'(err_cnt_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1;
    repeat (8) @(posedge clk_i); #1;
    check("t7_no_completion", 64'(n_rv - rv0), 64'd0);
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 64'hCAFE);
    issue(1'b0, 64'h308, '0, '0, "t7b");
    wait_rv(rv0 + 1, "t7b");
    check("t7_rdata", last_rdata, 64'hCAFE);

    repeat (3) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
